// File: rtl/tetris_pkg.sv
// Shared constants and helpers for the Tetris input controller.
//   - default parameter values for debounce length and base tick period
//   - position of the level field inside the score and the level cap
//   - command/button index map shared by the top and the bench
//   - score_level(): score -> speed level, saturated at LEVEL_CAP
package tetris_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 250000;
  localparam int unsigned TICK_BASE_DEF       = 25000000;

  // Level lives in score[7:5]; anything above LEVEL_CAP runs at the cap.
  localparam int unsigned LEVEL_LSB = 5;
  localparam int unsigned LEVEL_CAP = 3;

  localparam int unsigned NUM_BTNS   = 4;
  localparam int unsigned BTN_LEFT   = 0;
  localparam int unsigned BTN_RIGHT  = 1;
  localparam int unsigned BTN_ROTATE = 2;
  localparam int unsigned BTN_START  = 3;

  function automatic logic [1:0] score_level(input logic [7:0] score);
    logic [2:0] field;
    field = 3'(score >> LEVEL_LSB);
    if (field > 3'(LEVEL_CAP)) begin
      return 2'(LEVEL_CAP);
    end
    return field[1:0];
  endfunction

endpackage

// File: rtl/tetris_input_ctrl_if.sv
// Signal bundle between the board buttons / game FSM and the input controller.
//   left_btn, right_btn, rotate_btn, start_btn : raw asynchronous buttons
//   score_i, gameover_i                        : status from the game FSM
//   onehuzz                                    : square-wave game tick
//   left_i, right_i, rotate_r, start_i         : per-tick movement commands
// Modports: ctrl (the controller) and game (the board + game FSM side).
interface tetris_input_ctrl_if;

  logic       left_btn;
  logic       right_btn;
  logic       rotate_btn;
  logic       start_btn;
  logic [7:0] score_i;
  logic       gameover_i;
  logic       onehuzz;
  logic       left_i;
  logic       right_i;
  logic       rotate_r;
  logic       start_i;

  modport ctrl (
    input  left_btn, right_btn, rotate_btn, start_btn, score_i, gameover_i,
    output onehuzz, left_i, right_i, rotate_r, start_i
  );

  modport game (
    output left_btn, right_btn, rotate_btn, start_btn, score_i, gameover_i,
    input  onehuzz, left_i, right_i, rotate_r, start_i
  );

endinterface

// File: rtl/tetris_input_ctrl_button_debounce.sv
// button_debounce: 2-flop synchronizer, debounce filter and press detector
// for one raw button.
//   clk, reset_n : system clock, asynchronous active-low reset
//   btn_i        : raw asynchronous active-high button
//   press_o      : one-cycle pulse on an accepted 0->1 debounced transition
module button_debounce
  import tetris_pkg::*;
#(
  parameter int unsigned CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_i,
  output logic press_o
);

  // Arming needs a run of released samples long enough to also flush the
  // two synchronizer stages, which come out of reset reading 0 regardless
  // of the pin.  A button held through reset therefore never arms until it
  // has really been let go.
  localparam int unsigned ARM_CYCLES = CYCLES + 2;
  localparam int unsigned CW         = $clog2(ARM_CYCLES + 1);

  logic [1:0]    sync_q, sync_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic [CW-1:0] arm_cnt_q, arm_cnt_d;
  logic          press_q, press_d;
  logic          samp;

  always_comb begin
    samp      = sync_q[1];
    sync_d    = {sync_q[0], btn_i};
    level_d   = level_q;
    cnt_d     = cnt_q;
    armed_d   = armed_q;
    arm_cnt_d = arm_cnt_q;
    press_d   = 1'b0;

    if (samp != level_q) begin
      if (cnt_q == CW'(CYCLES - 1)) begin
        level_d = samp;
        cnt_d   = '0;
        press_d = samp & armed_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end

    if (!armed_q) begin
      if (!samp && !level_q) begin
        if (arm_cnt_q == CW'(ARM_CYCLES - 1)) begin
          armed_d = 1'b1;
        end else begin
          arm_cnt_d = arm_cnt_q + CW'(1);
        end
      end else begin
        arm_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      level_q   <= 1'b0;
      cnt_q     <= '0;
      armed_q   <= 1'b0;
      arm_cnt_q <= '0;
      press_q   <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      arm_cnt_q <= arm_cnt_d;
      press_q   <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/tetris_input_ctrl.sv
// tetris_input_ctrl: turns four raw buttons into per-tick game commands and
// generates the game tick whose speed follows the score.
//   clk, reset_n : system clock, asynchronous active-low reset
//   bus (ctrl)   : buttons, score_i, gameover_i in; onehuzz and the
//                  left_i/right_i/rotate_r/start_i commands out
// Commands change only on the falling edge of onehuzz and are held for one
// full tick period, so the game FSM sees them stable on every rising edge.
module tetris_input_ctrl
  import tetris_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned TICK_BASE       = TICK_BASE_DEF
) (
  input logic               clk,
  input logic               reset_n,
  tetris_input_ctrl_if.ctrl bus
);

  localparam int unsigned PW = $clog2(TICK_BASE + 1);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] press;

  assign btn_raw[BTN_LEFT]   = bus.left_btn;
  assign btn_raw[BTN_RIGHT]  = bus.right_btn;
  assign btn_raw[BTN_ROTATE] = bus.rotate_btn;
  assign btn_raw[BTN_START]  = bus.start_btn;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    button_debounce #(
      .CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_i   (btn_raw[g]),
      .press_o (press[g])
    );
  end

  // Tick generator.  The period is only reloaded at the wrap so a score
  // change never produces a truncated or stretched half-period.
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] period_q, period_d;
  logic [PW-1:0] period_next;
  logic [PW-1:0] half;
  logic          huzz_q, huzz_d;
  logic          wrap;
  logic          fall;

  always_comb begin
    half        = period_q >> 1;
    wrap        = (cnt_q == period_q - PW'(1));
    fall        = (cnt_q == half);
    period_next = PW'(TICK_BASE >> score_level(bus.score_i));
    cnt_d       = wrap ? '0 : cnt_q + PW'(1);
    period_d    = wrap ? period_next : period_q;
    huzz_d      = (cnt_q < half);
  end

  // Pending/command transfer.  On the falling tick edge the pending set is
  // cleared first and then re-seeded with any press arriving on that same
  // edge, so such a press lands in the following period.
  logic [NUM_BTNS-1:0] press_ok;
  logic [NUM_BTNS-1:0] pend_q, pend_d;
  logic [NUM_BTNS-1:0] cmd_q, cmd_d;
  logic                cancel;

  always_comb begin
    press_ok = press;
    cmd_d    = cmd_q;
    cancel   = pend_q[BTN_LEFT] & pend_q[BTN_RIGHT];

    if (bus.gameover_i) begin
      press_ok[BTN_LEFT]   = 1'b0;
      press_ok[BTN_RIGHT]  = 1'b0;
      press_ok[BTN_ROTATE] = 1'b0;
    end

    pend_d = fall ? press_ok : (pend_q | press_ok);

    if (fall) begin
      cmd_d = pend_q;
      if (cancel) begin
        cmd_d[BTN_LEFT]  = 1'b0;
        cmd_d[BTN_RIGHT] = 1'b0;
      end
      if (bus.gameover_i) begin
        cmd_d[BTN_LEFT]   = 1'b0;
        cmd_d[BTN_RIGHT]  = 1'b0;
        cmd_d[BTN_ROTATE] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      period_q <= PW'(TICK_BASE);
      huzz_q   <= 1'b0;
      pend_q   <= '0;
      cmd_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      huzz_q   <= huzz_d;
      pend_q   <= pend_d;
      cmd_q    <= cmd_d;
    end
  end

  assign bus.onehuzz  = huzz_q;
  assign bus.left_i   = cmd_q[BTN_LEFT];
  assign bus.right_i  = cmd_q[BTN_RIGHT];
  assign bus.rotate_r = cmd_q[BTN_ROTATE];
  assign bus.start_i  = cmd_q[BTN_START];

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Directed bench for tetris_input_ctrl with DEBOUNCE_CYCLES=4, TICK_BASE=16.
// Edge numbers in the comments count rising clk edges after reset release.
module tb_tetris_input_ctrl;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  tetris_input_ctrl_if bus ();

  tetris_input_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .TICK_BASE       (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Activity tally: index 0 left, 1 right, 2 rotate, 3 start.
  int         hi    [4];
  int         rises [4];
  int         toggles;
  logic [3:0] prev_cmd;
  logic       prev_huzz;

  function automatic logic [3:0] cmds();
    return {bus.start_i, bus.rotate_r, bus.right_i, bus.left_i};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_tally();
    for (int k = 0; k < 4; k++) begin
      hi[k]    = 0;
      rises[k] = 0;
    end
    toggles   = 0;
    prev_cmd  = cmds();
    prev_huzz = bus.onehuzz;
  endtask

  task automatic step();
    logic [3:0] cur;
    @(posedge clk);
    #1;
    cur = cmds();
    for (int k = 0; k < 4; k++) begin
      if (cur[k] === 1'b1) hi[k]++;
      if (cur[k] === 1'b1 && prev_cmd[k] !== 1'b1) rises[k]++;
    end
    if (bus.onehuzz !== prev_huzz) toggles++;
    prev_cmd  = cur;
    prev_huzz = bus.onehuzz;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.left_btn   = 1'b0;
    bus.right_btn  = 1'b0;
    bus.rotate_btn = 1'b0;
    bus.start_btn  = 1'b0;
    bus.score_i    = 8'd0;
    bus.gameover_i = 1'b0;
    clear_tally();

    // Reset state and first tick period (high E1..E8, falls at E9).
    #12;
    chk("reset_cmds", 32'(cmds()), 32'h0);
    chk("reset_huzz", 32'(bus.onehuzz), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("first_edge_high", 32'(bus.onehuzz), 32'h1);
    run(7);
    chk("high_8th", 32'(bus.onehuzz), 32'h1);
    step();
    chk("first_fall", 32'(bus.onehuzz), 32'h0);

    // Left held 10 cycles: pending by E16, asserted E25..E40.
    clear_tally();
    bus.left_btn = 1'b1;
    run(10);
    bus.left_btn = 1'b0;
    run(5);
    chk("left_before_fall", 32'(bus.left_i), 32'h0);
    step();
    chk("left_at_fall", 32'(bus.left_i), 32'h1);
    chk("huzz_at_fall", 32'(bus.onehuzz), 32'h0);
    run(20);
    chk("left_cycles", 32'(hi[0]), 32'd16);
    chk("left_rises", 32'(rises[0]), 32'd1);
    chk("others_quiet_a", 32'(hi[1] + hi[2] + hi[3]), 32'd0);

    // Rotate bounce alone, then bounce followed by steady press.
    clear_tally();
    bus.rotate_btn = 1'b1; step();
    bus.rotate_btn = 1'b0; step();
    bus.rotate_btn = 1'b1; step();
    bus.rotate_btn = 1'b0; step();
    run(20);
    chk("bounce_only", 32'(hi[2]), 32'd0);
    bus.rotate_btn = 1'b1; step();
    bus.rotate_btn = 1'b0; step();
    bus.rotate_btn = 1'b1; step();
    bus.rotate_btn = 1'b0; step();
    bus.rotate_btn = 1'b1;
    run(8);
    bus.rotate_btn = 1'b0;
    run(29);
    chk("rotate_cycles", 32'(hi[2]), 32'd16);
    chk("rotate_rises", 32'(rises[2]), 32'd1);

    // Left+right cancel each other, rotate in the same period still goes.
    clear_tally();
    bus.left_btn   = 1'b1;
    bus.right_btn  = 1'b1;
    bus.rotate_btn = 1'b1;
    run(8);
    bus.left_btn   = 1'b0;
    bus.right_btn  = 1'b0;
    bus.rotate_btn = 1'b0;
    run(24);
    chk("cancel_left", 32'(hi[0]), 32'd0);
    chk("cancel_right", 32'(hi[1]), 32'd0);
    chk("cancel_rotate", 32'(hi[2]), 32'd16);

    // Right alone.
    clear_tally();
    bus.right_btn = 1'b1;
    run(6);
    bus.right_btn = 1'b0;
    run(30);
    chk("right_cycles", 32'(hi[1]), 32'd16);
    chk("right_left_quiet", 32'(hi[0]), 32'd0);

    // Start press pulse lands on the E185 transfer edge: next period only.
    bus.start_btn = 1'b1;
    run(6);
    bus.start_btn = 1'b0;
    step();
    chk("coincide_not_now", 32'(bus.start_i), 32'h0);
    run(16);
    chk("coincide_next", 32'(bus.start_i), 32'h1);
    run(16);
    chk("coincide_cleared", 32'(bus.start_i), 32'h0);

    // Score 64 mid-period: current period stays 16, next P=4.
    bus.score_i = 8'd64;
    run(7);
    chk("old_period_low", 32'(bus.onehuzz), 32'h0);
    step();
    step();
    chk("p4_high", 32'(bus.onehuzz), 32'h1);
    step();
    chk("p4_low", 32'(bus.onehuzz), 32'h0);
    step();
    step();
    chk("p4_rise", 32'(bus.onehuzz), 32'h1);

    // Score 32 -> P=8 (4 high / 4 low) from the next wrap.
    bus.score_i = 8'd32;
    run(7);
    chk("p8_high_end", 32'(bus.onehuzz), 32'h1);
    step();
    chk("p8_low_start", 32'(bus.onehuzz), 32'h0);
    run(3);
    chk("p8_low_end", 32'(bus.onehuzz), 32'h0);
    step();
    chk("p8_rise", 32'(bus.onehuzz), 32'h1);

    // Score 255 saturates at level 3 -> P=2.
    bus.score_i = 8'd255;
    run(8);
    chk("p2_high", 32'(bus.onehuzz), 32'h1);
    step();
    chk("p2_low", 32'(bus.onehuzz), 32'h0);
    step();
    chk("p2_rise", 32'(bus.onehuzz), 32'h1);
    bus.score_i = 8'd0;
    step();
    step();

    // Game over: only start passes, tick keeps running.
    bus.gameover_i = 1'b1;
    clear_tally();
    bus.left_btn   = 1'b1;
    bus.rotate_btn = 1'b1;
    bus.start_btn  = 1'b1;
    run(8);
    bus.left_btn   = 1'b0;
    bus.rotate_btn = 1'b0;
    bus.start_btn  = 1'b0;
    run(24);
    chk("go_start", 32'(hi[3]), 32'd16);
    chk("go_left", 32'(hi[0]), 32'd0);
    chk("go_rotate", 32'(hi[2]), 32'd0);
    chk("go_huzz_toggles", 32'(toggles), 32'd4);

    // Rotate pending before game over is dropped at the transfer.
    bus.gameover_i = 1'b0;
    bus.rotate_btn = 1'b1;
    run(6);
    bus.rotate_btn = 1'b0;
    step();
    bus.gameover_i = 1'b1;
    clear_tally();
    run(20);
    chk("go_mask_transfer", 32'(hi[2]), 32'd0);
    bus.gameover_i = 1'b0;

    // Reset mid-high-phase with left pending.
    bus.left_btn = 1'b1;
    run(6);
    bus.left_btn = 1'b0;
    step();
    step();
    chk("pre_reset_high", 32'(bus.onehuzz), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_huzz", 32'(bus.onehuzz), 32'h0);
    chk("async_reset_cmds", 32'(cmds()), 32'h0);
    run(2);
    chk("in_reset_huzz", 32'(bus.onehuzz), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    clear_tally();
    step();
    chk("rst2_first_high", 32'(bus.onehuzz), 32'h1);
    run(7);
    chk("rst2_high_8th", 32'(bus.onehuzz), 32'h1);
    step();
    chk("rst2_fall", 32'(bus.onehuzz), 32'h0);
    run(30);
    chk("rst2_no_left", 32'(hi[0]), 32'd0);

    // Start held through reset is ignored until released and re-pressed.
    bus.start_btn = 1'b1;
    reset_n = 1'b0;
    step();
    @(negedge clk);
    reset_n = 1'b1;
    clear_tally();
    run(12);
    bus.start_btn = 1'b0;
    run(40);
    chk("held_through_reset", 32'(rises[3]), 32'd0);
    bus.start_btn = 1'b1;
    run(6);
    bus.start_btn = 1'b0;
    run(40);
    chk("repress_after_reset", 32'(rises[3]), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
